// File: rtl/global_types.sv
// Shared stream and filter-mode types for the packet filter path.
// No logic; types and a mode decode helper only.
// Not applicable (package).
package global_types;

    // Avalon-ST beat as carried between blocks on this path.
    typedef struct packed {
        logic        valid;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic [63:0] data;
    } avln_st;

    // Encoding 3 is not named and behaves as PASS_ALL.
    typedef enum logic [1:0] {
        PASS_ALL   = 2'd0,
        DROP_FOUND = 2'd1,
        KEEP_FOUND = 2'd2
    } filt_mode_t;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } pkt_state_t;

    // Turn a per-packet match verdict into a drop decision for the given mode.
    function automatic logic drop_for(input filt_mode_t mode, input logic verdict);
        case (mode)
            DROP_FOUND: return verdict;
            KEEP_FOUND: return ~verdict;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/packet_filter_gate_verdict_fifo.sv
// 1-bit verdict queue with occupancy; pop on empty falls through to a same-cycle push.
// pop_dat is combinational from the head (or the push input when empty); state updates next edge.
// No stalls: a push while full is dropped, a pop while empty without push reads 0.
module verdict_fifo
    #(
    parameter int DEPTH = 32
    )
    (
    input  logic                     sys_clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     push_dat,
    input  logic                     pop,
    output logic                     pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          mem [DEPTH];
    logic          wr_en;
    logic          rd_en;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH[AW:0]);
    // A push consumed by a fall-through pop never lands in storage.
    assign wr_en   = push & ~full & ~(pop & empty);
    assign rd_en   = pop & ~empty;
    assign pop_dat = empty ? (push & push_dat) : mem[rd_ptr];
    assign level   = count;

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge sys_clk) begin
        if (wr_en) mem[wr_ptr] <= push_dat;
    end

    // Pointer and occupancy tracking; pointers wrap naturally at a power-of-2 depth.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/packet_filter_gate.sv
// Packet-atomic drop/keep gate: queues delayed match verdicts and applies them per packet.
// One registered cycle from fifo_out to out.
// No backpressure: every valid fifo_out beat is consumed; verdict queue errors are flagged.
module packet_filter_gate
    import global_types::*;
    #(
    parameter int FOUND_DELAY   = 4,
    parameter int VERDICT_DEPTH = 32,
    parameter int CNT_W         = 32
    )
    (
    input  logic                             sys_clk,
    input  logic                             reset_n,
    input  avln_st                           in,
    input  logic                             found,
    input  avln_st                           fifo_out,
    output avln_st                           out,
    input  filt_mode_t                       cfg_mode,
    input  logic                             stat_clear,
    output logic [CNT_W-1:0]                 pkt_pass_cnt,
    output logic [CNT_W-1:0]                 pkt_drop_cnt,
    output logic                             vq_overflow,
    output logic                             vq_underflow,
    output logic [$clog2(VERDICT_DEPTH):0]   vq_level
);
    logic [FOUND_DELAY-1:0] sop_sr;
    logic                   push;
    logic                   pop;
    logic                   pop_dat;
    logic                   vq_full;
    logic                   vq_empty;
    pkt_state_t             state;
    pkt_state_t             state_nxt;
    logic                   drop_q;
    logic                   drop_nxt;
    logic                   cur_drop;
    logic                   tracked;
    logic                   eop_evt;
    logic                   unused_in;

    // Only sop/valid of the ingress stream matter here.
    assign unused_in = ^{in.eop, in.empty, in.data};

    assign push    = sop_sr[FOUND_DELAY-1];
    assign eop_evt = fifo_out.valid & fifo_out.eop & tracked;

    // Delay line marking the cycle in which `found` belongs to an accepted sop.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            sop_sr <= '0;
        end else begin
            sop_sr[0] <= in.valid & in.sop;
            for (int i = 1; i < FOUND_DELAY; i++) sop_sr[i] <= sop_sr[i-1];
        end
    end

    verdict_fifo #(.DEPTH(VERDICT_DEPTH)) u_vq (
        .sys_clk  (sys_clk),
        .reset_n  (reset_n),
        .push     (push),
        .push_dat (found),
        .pop      (pop),
        .pop_dat  (pop_dat),
        .full     (vq_full),
        .empty    (vq_empty),
        .level    (vq_level)
    );

    // Packet state and the drop decision held from sop through eop.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            drop_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            drop_q <= drop_nxt;
        end
    end

    // A sop always opens a new packet (even mid-packet) and takes the next verdict.
    always_comb begin
        state_nxt = state;
        drop_nxt  = drop_q;
        cur_drop  = drop_q;
        tracked   = (state == IN_PKT);
        pop       = 1'b0;
        if (fifo_out.valid && fifo_out.sop) begin
            pop       = 1'b1;
            tracked   = 1'b1;
            cur_drop  = drop_for(cfg_mode, pop_dat);
            drop_nxt  = cur_drop;
            state_nxt = fifo_out.eop ? IDLE : IN_PKT;
        end else if (fifo_out.valid && fifo_out.eop && state == IN_PKT) begin
            state_nxt = IDLE;
        end
    end

    // Output register; orphan beats outside a packet are never marked valid.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            out <= '0;
        end else begin
            out.data  <= fifo_out.data;
            out.sop   <= fifo_out.sop;
            out.eop   <= fifo_out.eop;
            out.empty <= fifo_out.empty;
            out.valid <= fifo_out.valid & tracked & ~cur_drop;
        end
    end

    // Saturating per-packet statistics; clear beats a same-cycle increment.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_pass_cnt <= '0;
            pkt_drop_cnt <= '0;
        end else if (stat_clear) begin
            pkt_pass_cnt <= '0;
            pkt_drop_cnt <= '0;
        end else if (eop_evt) begin
            if (cur_drop) begin
                if (!(&pkt_drop_cnt)) pkt_drop_cnt <= pkt_drop_cnt + 1'b1;
            end else begin
                if (!(&pkt_pass_cnt)) pkt_pass_cnt <= pkt_pass_cnt + 1'b1;
            end
        end
    end

    // Sticky queue error flags.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            vq_overflow  <= 1'b0;
            vq_underflow <= 1'b0;
        end else if (stat_clear) begin
            vq_overflow  <= 1'b0;
            vq_underflow <= 1'b0;
        end else begin
            if (push && vq_full)             vq_overflow  <= 1'b1;
            if (pop && vq_empty && !push)    vq_underflow <= 1'b1;
        end
    end

endmodule
